// File: rtl/countdown_timer_if.sv
// Load/control/status bundle for countdown_timer.
// The master side issues loads and controls the count.
// The slave side is the timer itself.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    // Load handshake
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             auto_reload;

    // Run control
    logic             enable;
    logic             abort;

    // Status
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             expired;

    modport master (
        output load_valid,
        output load_value,
        output auto_reload,
        output enable,
        output abort,
        input  load_ready,
        input  count,
        input  busy,
        input  expired
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  auto_reload,
        input  enable,
        input  abort,
        output load_ready,
        output count,
        output busy,
        output expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse and optional
// periodic reload.
// Control is a three-state FSM: IDLE accepts a load, RUN decrements under
// enable, and DONE lasts exactly one cycle and drives expired.
module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_reg,      state_next;
    logic [WIDTH-1:0] count_reg,      count_next;
    logic [WIDTH-1:0] reload_val_reg, reload_val_next;
    logic             reload_en_reg,  reload_en_next;

    // A load is taken only while IDLE, and never in the same cycle as abort.
    logic load_fire;
    // The counter is at its last step.
    // Counts below one cannot occur in RUN; they are folded in as a guard.
    logic count_last;
    logic reload_ok;

    assign load_fire  = bus.load_valid && (state_reg == ST_IDLE) && !bus.abort;
    assign count_last = (count_reg <= ONE);
    assign reload_ok  = reload_en_reg && (reload_val_reg != ZERO);

    // State register: reset forces IDLE immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    // abort overrides every transition, and DONE always leaves after one cycle.
    always_comb begin
        state_next = state_reg;
        if (bus.abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (load_fire) begin
                        // A zero load has nothing to count and expires at once.
                        state_next = (bus.load_value != ZERO) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (bus.enable && count_last) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_next = reload_ok ? ST_RUN : ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath next values: count, captured reload value and reload mode.
    always_comb begin
        count_next      = count_reg;
        reload_val_next = reload_val_reg;
        reload_en_next  = reload_en_reg;
        if (bus.abort) begin
            // Cancel clears the count and stops any periodic loop.
            // reload_val may keep a stale value because reload_en gates it.
            count_next     = ZERO;
            reload_en_next = 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (load_fire) begin
                        count_next      = bus.load_value;
                        reload_val_next = bus.load_value;
                        reload_en_next  = bus.auto_reload;
                    end
                end
                ST_RUN: begin
                    if (bus.enable) begin
                        // count_last covers count==1; dropping to zero here
                        // means the count can never wrap below zero.
                        count_next = count_last ? ZERO : (count_reg - ONE);
                    end
                end
                ST_DONE: begin
                    // enable is deliberately not looked at here.
                    // The reload period is therefore N+1 cycles.
                    count_next = reload_ok ? reload_val_reg : ZERO;
                end
                default: begin
                    count_next = ZERO;
                end
            endcase
        end
    end

    // Datapath registers: reset clears them together with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg      <= ZERO;
            reload_val_reg <= ZERO;
            reload_en_reg  <= 1'b0;
        end else begin
            count_reg      <= count_next;
            reload_val_reg <= reload_val_next;
            reload_en_reg  <= reload_en_next;
        end
    end

    // Output decode.
    // Every output is a function of registered state only, so it is glitch-free.
    // expired cannot repeat on consecutive cycles because DONE never follows DONE.
    always_comb begin
        bus.load_ready = (state_reg == ST_IDLE);
        bus.busy       = (state_reg != ST_IDLE);
        bus.expired    = (state_reg == ST_DONE);
        bus.count      = count_reg;
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer.
// The stimulus side predicts the cycle of every expired pulse from the
// enable pattern and queues it; a monitor compares the actual pulses.
module tb_countdown_timer;
    localparam int W = 8;
    localparam int L = 1024;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(W)) bus ();

    countdown_timer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];       // cycle numbers where expired must be high
    bit en[L];          // enable pattern, index i applies to edge k+i+1

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Offset of the edge that consumes the need-th enable-high cycle
    // counting from edge start+1. Returns start when need is zero.
    function automatic int nth_one(input int start, input int need);
        int i;
        int left;
        i = start;
        left = need;
        while (left > 0) begin
            if (i >= L) return -1;
            i++;
            if (en[i-1]) left--;
        end
        return i;
    endfunction

    // Monitor: every expired pulse must match the head of the queue.
    bit prev_exp = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_exp <= 1'b0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                check("expired_pulse", bus.expired, 1);
                check("expired_count", bus.count, 0);
                void'(exp_q.pop_front());
            end else if (bus.expired) begin
                check("spurious_expired", bus.expired, 0);
            end
            if (bus.expired) check("expired_single", prev_exp, 0);
            prev_exp <= bus.expired;
        end
    end

    // Run one load transaction.
    // The task must be entered just after a falling edge.
    task automatic do_txn(input int n, input bit auto_r, input int pct, input int abort_j,
                          input bit hold, input int hold_val, input bit keep_en);
        int k, m, pos, d, ones, a_rel, npulse;
        if (!keep_en)
            for (int i = 0; i < L; i++) en[i] = (i >= 700) ? 1'b1 : ($urandom_range(99) < pct);
        check("ready_before_load", bus.load_ready, 1);
        k = cyc + 1;
        a_rel = (abort_j >= 0) ? abort_j + 1 : L + 10;
        pos = 0;
        npulse = 0;
        while (1) begin
            d = nth_one(pos, n);
            if (d < 0 || d >= a_rel) break;
            exp_q.push_back(k + d);
            npulse++;
            if (!auto_r || n == 0) break;
            pos = d + 1;
            if (pos >= a_rel) break;
        end
        m = nth_one(0, n);
        bus.load_valid  = 1'b1;
        bus.load_value  = W'(n);
        bus.auto_reload = auto_r;
        bus.abort       = 1'b0;
        bus.enable      = 1'($urandom_range(1));
        @(negedge clk);
        bus.load_valid = hold;
        if (hold) bus.load_value = W'(hold_val);
        check("load_busy", bus.busy, 1);
        if (abort_j < 0) begin
            ones = 0;
            for (int j = 0; j <= m; j++) begin
                check("count_run", bus.count, n - ones);
                bus.enable = en[j];
                if (en[j]) ones++;
                @(negedge clk);
            end
        end else begin
            for (int j = 0; j <= abort_j; j++) begin
                bus.enable = en[j];
                bus.abort  = (j == abort_j);
                @(negedge clk);
            end
            bus.abort = 1'b0;
        end
        bus.enable = 1'b0;
        check("idle_ready", bus.load_ready, 1);
        check("idle_busy", bus.busy, 0);
        check("idle_count", bus.count, 0);
        $display("[TB] txn load=%0d auto=%0d abort_j=%0d hold=%0d pulses=%0d start_cycle=%0d",
                 n, auto_r, abort_j, hold, npulse, k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, p, aj;
        bus.load_valid  = 1'b0;
        bus.load_value  = '0;
        bus.auto_reload = 1'b0;
        bus.enable      = 1'b0;
        bus.abort       = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count", bus.count, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_expired", bus.expired, 0);
        check("rst_ready", bus.load_ready, 1);
        reset = 1'b1;
        @(negedge clk);

        // One-shot with enable held high
        do_txn(5, 0, 100, -1, 0, 0, 0);

        // Enable gaps 1,0,0,1,1
        for (int i = 0; i < L; i++) en[i] = 1'b1;
        en[1] = 1'b0;
        en[2] = 1'b0;
        do_txn(3, 0, 0, -1, 0, 0, 1);

        // Auto-reload, then abort
        do_txn(2, 1, 100, 10, 0, 0, 0);
        repeat (6) @(negedge clk);

        // Edge values
        do_txn(0, 0, 100, -1, 0, 0, 0);
        do_txn(255, 0, 100, -1, 0, 0, 0);
        do_txn(0, 1, 100, -1, 0, 0, 0);
        repeat (4) @(negedge clk);

        // load_valid held through RUN with another value, then accepted once
        do_txn(4, 0, 100, -1, 1, 9, 0);
        do_txn(9, 0, 100, -1, 0, 0, 0);
        repeat (4) @(negedge clk);

        // abort with load_valid in the same cycle discards the load
        bus.load_valid = 1'b1;
        bus.load_value = 8'd6;
        bus.abort      = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.abort      = 1'b0;
        check("abortload_busy", bus.busy, 0);
        check("abortload_count", bus.count, 0);
        check("abortload_ready", bus.load_ready, 1);
        @(negedge clk);
        check("abortload_still_idle", bus.busy, 0);
        $display("[TB] txn abort+load same cycle");

        // Asynchronous reset in RUN at count 7
        bus.load_valid = 1'b1;
        bus.load_value = 8'd10;
        bus.enable     = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_count", bus.count, 7);
        #2 reset = 1'b0;
        #1;
        check("async_rst_count", bus.count, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_expired", bus.expired, 0);
        check("async_rst_ready", bus.load_ready, 1);
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("[TB] txn async reset mid-run");
        do_txn(3, 0, 100, -1, 0, 0, 0);

        // Randomized transactions
        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(40);
            a = $urandom_range(1);
            p = $urandom_range(100, 30);
            if (a && n != 0) aj = $urandom_range(120, 5);
            else aj = ($urandom_range(3) == 0) ? $urandom_range(50) : -1;
            do_txn(n, a[0], p, aj, 0, 0, 0);
            repeat ($urandom_range(3)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        check("pending_expected", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter companion to the free-running up `counter`. It accepts a start value over a valid/ready load handshake and decrements it to zero under an enable. It issues a one-cycle `expired` pulse at terminal count and optionally reloads itself for periodic operation. It sits beside `counter` in the same clock domain as the timeout/interval source for control logic.

## Interface
- `WIDTH`, 8, counter and load-value width (>= 2)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately
- `load_valid`  in  1  load request
- `load_ready`  out  1  block can accept a load (high only in IDLE)
- `load_value`  in  WIDTH  start value, captured on handshake
- `auto_reload`  in  1  periodic mode select, captured with `load_value`
- `enable`  in  1  decrement qualifier, honoured only in RUN
- `abort`  in  1  synchronous cancel
- `count`  out  WIDTH  current counter value (registered)
- `busy`  out  1  state != IDLE
- `expired`  out  1  one-cycle terminal-count pulse (registered)

## Operation
- Internal registers: `state` {IDLE, RUN, DONE}, `count`, `reload_val[WIDTH]`, `reload_en`.
- Reset (reset=0): state=IDLE, count=0, reload_val=0, reload_en=0, expired=0; hence load_ready=1, busy=0.
- Priority each edge: reset > abort > state logic.
- abort=1 in any state: next state IDLE, count←0, reload_en←0, no expired pulse. Any load presented in the same cycle is discarded.
- IDLE: load_ready=1. On load_valid&load_ready: count←load_value, reload_val←load_value, reload_en←auto_reload.
  - load_value≠0 → RUN.
  - load_value=0 → DONE.
- RUN: load_ready=0 and load_valid is ignored.
  - enable=1, count>1: count←count−1.
  - enable=1, count=1: count←0, →DONE.
  - enable=0: hold.
- DONE (exactly one cycle): expired=1, count=0.
  - reload_en=1 and reload_val≠0: count←reload_val, →RUN.
  - Otherwise →IDLE.
  - enable is ignored in DONE.
- expired is a decode of registered state (state==DONE), glitch-free, never high for two consecutive cycles.
- Arithmetic is unsigned WIDTH-bit. count never wraps below 0; underflow is impossible by construction.
- Maximum load is 2^WIDTH−1 (255 at default).

## Timing
- Load handshake completes at edge k. count=load_value and busy=1 are visible after edge k.
- With enable held high and load N≥1:
  - count reaches 0 after edge k+N.
  - expired=1 in the cycle after edge k+N.
  - One-shot: load_ready=1 again after edge k+N+1.
- Load 0: expired=1 in the cycle after edge k; IDLE after edge k+1.
- Auto-reload period with enable held high: N+1 cycles between expired pulses.
- Each enable-low cycle in RUN adds exactly one cycle of latency.
- abort asserted for edge j: IDLE, count=0 and load_ready=1 visible after edge j.
- reset deassertion is synchronised externally. The first load is accepted no earlier than the first edge with reset=1.

## Test plan
- Reset then one-shot: load 5 with enable=1 → count 5,4,3,2,1,0 on successive cycles; expired high exactly one cycle (count=0); load_ready returns 1 the next cycle.
- Enable gaps: load 3, enable pattern 1,0,0,1,1 → count 3,2,2,2,1,0; expired in the cycle after count reaches 0; total latency 5+1 cycles.
- Auto-reload: load 2 with auto_reload=1, enable=1 → count 2,1,0,2,1,0,…; expired every 3 cycles; abort stops it to IDLE, count 0, no further pulses.
- Edge values:
  - load 0 → single expired pulse next cycle, busy low after.
  - load 255 → 255 decrements, then expired.
  - load 0 with auto_reload=1 → one pulse only, no loop.
- Handshake: load_valid held through RUN with a different value → ignored until IDLE, then accepted once; abort and load_valid in the same cycle → load discarded.
- Async reset mid-RUN (count=7) → count=0, busy=0, expired=0 immediately without a clock edge; normal load accepted after release.
